// File: rtl/clock_ctrl.sv
// Mode and carry controller for the real-time clock: seconds tick and 59->0 carries
// in RUN, single and auto-repeat increment pulses in the SET modes.
module clock_ctrl #(
    parameter int HOLD_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tc_time_base,
    input  logic [5:0] q_seconds,
    input  logic [5:0] q_minutes,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       en_seconds,
    output logic       en_minutes,
    output logic       en_hours,
    output logic       clr_seconds,
    output logic [1:0] mode,
    output logic       blink
);

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_TICKS);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        SET_HOURS   = 2'd1,
        SET_MINUTES = 2'd2,
        SET_SECONDS = 2'd3
    } state_t;

    state_t     state;
    logic       btn_mode_prev;
    logic       btn_inc_prev;
    logic       hold_arm;
    logic [3:0] hold_cnt;

    logic       mode_press;
    logic       inc_press;
    logic       in_repeat_mode;
    logic       repeat_tick;
    logic       inc_fire;
    logic       carry_sec;
    logic       carry_min;
    logic       nxt_en_seconds;
    logic       nxt_en_minutes;
    logic       nxt_en_hours;
    logic       nxt_clr_seconds;
    logic       nxt_hold_arm;
    logic [3:0] nxt_hold_cnt;

    function automatic state_t next_mode(input state_t s);
        case (s)
            RUN:         next_mode = SET_HOURS;
            SET_HOURS:   next_mode = SET_MINUTES;
            SET_MINUTES: next_mode = SET_SECONDS;
            default:     next_mode = RUN;
        endcase
    endfunction

    // Hold counter saturates at the repeat threshold so it can never wrap.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        sat_inc = (v >= HOLD_LIM) ? v : v + 4'd1;
    endfunction

    always_comb begin
        mode_press     = btn_mode & ~btn_mode_prev;
        inc_press      = btn_inc & ~btn_inc_prev & ~mode_press;
        in_repeat_mode = (state == SET_HOURS) || (state == SET_MINUTES);
        carry_sec      = (q_seconds == 6'd59);
        carry_min      = (q_minutes == 6'd59);
        repeat_tick    = in_repeat_mode & hold_arm & btn_inc & tc_time_base
                         & (hold_cnt >= HOLD_LIM) & ~mode_press;
        inc_fire       = inc_press | repeat_tick;

        nxt_en_seconds  = 1'b0;
        nxt_en_minutes  = 1'b0;
        nxt_en_hours    = 1'b0;
        nxt_clr_seconds = 1'b0;
        case (state)
            RUN: begin
                nxt_en_seconds = tc_time_base;
                nxt_en_minutes = tc_time_base & carry_sec;
                nxt_en_hours   = tc_time_base & carry_sec & carry_min;
            end
            SET_HOURS:   nxt_en_hours    = inc_fire;
            SET_MINUTES: nxt_en_minutes  = inc_fire;
            SET_SECONDS: nxt_clr_seconds = inc_press;
            default: ;
        endcase

        // Repeat is armed only by a press seen in a repeat-capable mode, so a
        // button already held when entering SET does not start repeating.
        nxt_hold_arm = hold_arm;
        nxt_hold_cnt = hold_cnt;
        if (mode_press || !btn_inc || !in_repeat_mode) begin
            nxt_hold_arm = 1'b0;
            nxt_hold_cnt = 4'd0;
        end else if (inc_press) begin
            nxt_hold_arm = 1'b1;
            nxt_hold_cnt = 4'd0;
        end else if (hold_arm && tc_time_base) begin
            nxt_hold_cnt = sat_inc(hold_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            btn_mode_prev <= 1'b1;
            btn_inc_prev  <= 1'b1;
            hold_arm      <= 1'b0;
            hold_cnt      <= 4'd0;
            en_seconds    <= 1'b0;
            en_minutes    <= 1'b0;
            en_hours      <= 1'b0;
            clr_seconds   <= 1'b0;
            blink         <= 1'b0;
        end else begin
            btn_mode_prev <= btn_mode;
            btn_inc_prev  <= btn_inc;
            hold_arm      <= nxt_hold_arm;
            hold_cnt      <= nxt_hold_cnt;
            if (mode_press) begin
                state <= next_mode(state);
            end
            // Masking with the current value guarantees no back-to-back pulses.
            en_seconds  <= nxt_en_seconds & ~en_seconds;
            en_minutes  <= nxt_en_minutes & ~en_minutes;
            en_hours    <= nxt_en_hours & ~en_hours;
            clr_seconds <= nxt_clr_seconds & ~clr_seconds;
            if (mode_press || state == RUN) begin
                blink <= 1'b0;
            end else if (tc_time_base) begin
                blink <= ~blink;
            end
        end
    end

    assign mode = state;

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Mode and carry controller for the real-time clock. Sits between the 1 Hz time base and the seconds, minutes and hours counters, and drives their count enables. In RUN mode it produces the seconds tick and the 59→0 carries into minutes and hours. In the three SET modes it freezes normal counting and turns a user increment button into single or auto-repeating count pulses for the selected field.

## Interface
Parameters:
- HOLD_TICKS, default 2: number of tc_time_base pulses btn_inc must stay held after its press before auto-repeat starts; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tc_time_base  in  1  one-cycle 1 Hz tick.
- q_seconds  in  6  current seconds count, 0..59.
- q_minutes  in  6  current minutes count, 0..59.
- btn_mode  in  1  debounced mode button, level.
- btn_inc  in  1  debounced increment button, level.
- en_seconds  out  1  count enable pulse to the seconds counter (its tc_time_base input).
- en_minutes  out  1  count enable pulse to the minutes counter.
- en_hours  out  1  count enable pulse to the hours counter.
- clr_seconds  out  1  synchronous clear pulse to the seconds counter.
- mode  out  2  current state: 0 RUN, 1 SET_HOURS, 2 SET_MINUTES, 3 SET_SECONDS.
- blink  out  1  display blink phase for the selected field.

## Operation
- One clock domain. Reset is synchronous and active-high.
- Reset values: all outputs are 0 and mode = RUN.
- Edge detection:
  - Both button "previous" registers reset to 1, so a button held through reset release is not a press.
  - A press is a 0→1 change seen on a clock edge.
- State machine:
  - A btn_mode press advances RUN→SET_HOURS→SET_MINUTES→SET_SECONDS→RUN.
  - No other transitions exist.
- RUN:
  - tc_time_base gives en_seconds.
  - tc_time_base with q_seconds==59 also gives en_minutes.
  - tc_time_base with q_seconds==59 and q_minutes==59 also gives en_hours.
  - btn_inc is ignored.
- SET_HOURS / SET_MINUTES:
  - en_seconds is held at 0, so the time is frozen.
  - A btn_inc press gives one pulse on en_hours or en_minutes respectively.
  - There is no carry between fields in SET modes.
- Auto-repeat (SET_HOURS / SET_MINUTES only):
  - A 4-bit hold counter clears on each press.
  - It increments on each tc_time_base while btn_inc stays high.
  - Once it reaches HOLD_TICKS, every later tc_time_base with btn_inc high gives one pulse on the selected enable.
  - Releasing btn_inc, or any mode change, clears the hold counter and stops repeating.
- SET_SECONDS:
  - en_seconds is held at 0.
  - A btn_inc press gives one clr_seconds pulse. There is no auto-repeat.
- blink:
  - Forced to 0 in RUN.
  - Cleared to 0 on every mode change.
  - Toggles on each tc_time_base while in a SET state.
- Priorities and invariants:
  - A btn_mode press in the same cycle as a btn_inc press: the mode press wins and the inc press is discarded.
  - A press and an auto-repeat tick in the same cycle give one pulse, not two.
  - At most one pulse per enable per cycle.
  - en_* and clr_seconds are never high for two consecutive cycles.
- Reset asserted mid-operation (for example during auto-repeat or with a pulse pending) drops every output to 0 on the next edge and returns mode to RUN. No pending pulse is emitted after reset.

## Timing
- All outputs are registered.
- Events on inputs sampled at edge N appear on outputs after edge N+1. Latency is one cycle.
- Pulse outputs are exactly one clk cycle wide.
- RUN carry:
  - en_seconds, en_minutes and en_hours for the same tick assert in the same cycle.
  - The decision uses q_seconds and q_minutes sampled in the tc_time_base cycle. These values are stable because seconds only change on en_seconds.
- mode updates one cycle after the btn_mode press.
- The first SET-mode behaviour applies to btn_inc presses sampled after the mode change is visible.
- Leaving SET_SECONDS for RUN: counting resumes at the next tc_time_base after mode reads 0.

## Test plan
- Reset, then 60 tc_time_base pulses in RUN with the counters modelled:
  - en_seconds pulses 60 times.
  - en_minutes pulses exactly once, on the tick where q_seconds==59.
  - en_hours stays 0.
- q_seconds=59 and q_minutes=59 with a tc_time_base in RUN -> en_seconds, en_minutes and en_hours all high in the same single cycle, one cycle after the tick.
- Four btn_mode presses -> mode sequence 1, 2, 3, 0. blink is 0 after each change and toggles on tc_time_base only while mode≠0.
- SET_MINUTES, btn_inc held across 5 tc_time_base ticks with HOLD_TICKS=2 -> 1 press pulse plus 3 repeat pulses on en_minutes (4 total). en_seconds stays 0. Release stops the pulses.
- SET_SECONDS, btn_inc press -> one clr_seconds pulse. Holding btn_inc through 4 ticks produces no further pulses.
- btn_mode and btn_inc pressed in the same cycle in SET_HOURS -> mode becomes 2 and no en_hours pulse. Reset during auto-repeat -> all outputs 0 and mode 0 on the next cycle.
